rs_enc_lfsr: RTL and testbench



---
 rtl/rs_enc_pkg.sv | 81 ++++++++
 rtl/rs_enc_stage.sv | 55 +++++
 rtl/rs_enc_lfsr.sv | 160 ++++++++++++++++
 tb/tb_rs_enc_lfsr.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_enc_pkg.sv
// -----------------------------------------------------------------------------
// rs_enc_pkg
// Shared definitions for the rs_enc_lfsr Reed-Solomon encoder:
//   - GF(2^8) arithmetic used at elaboration time only (gf_mul, gf_pow_alpha,
//     gen_poly, gf_const_cols). None of these becomes a runtime multiplier;
//     they produce constants that parameterise the parity stages.
//   - Encoder state enum.
//   - Default field polynomial and first consecutive root.
// -----------------------------------------------------------------------------
package rs_enc_pkg;

    localparam logic [8:0] PRIM_POLY_DEF = 9'h11D;
    localparam int         FCR_DEF       = 0;
    localparam int         N_PARITY_MAX  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MSG    = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    // Generator coefficients g0..g(N-1); the monic x^N term is implicit.
    typedef logic [N_PARITY_MAX-1:0][7:0] gen_coef_t;

    // Columns of the 8x8 GF(2) matrix for multiplication by a constant:
    // col[j] = coef * x^j, so coef*v = XOR of col[j] over set bits of v.
    typedef logic [7:0][7:0] gf_cols_t;

    // Shift-and-add multiply, reducing by the field polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [8:0] poly);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = aa[7] ? ((aa << 1) ^ poly[7:0]) : (aa << 1);
        end
        return acc;
    endfunction

    // alpha^e with alpha = x (0x02); exponent taken modulo 255.
    function automatic logic [7:0] gf_pow_alpha(input int e,
                                                input logic [8:0] poly);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < (e % 255); i++) p = gf_mul(p, 8'h02, poly);
        return p;
    endfunction

    // g(x) = prod_{i=0..n-1} (x + alpha^(fcr+i)), built one root at a time.
    function automatic gen_coef_t gen_poly(input int n,
                                           input logic [8:0] poly,
                                           input int fcr);
        logic [7:0] g [0:N_PARITY_MAX];
        logic [7:0] root;
        gen_coef_t  res;
        for (int j = 0; j <= N_PARITY_MAX; j++) g[j] = 8'h00;
        g[0] = 8'h01;
        for (int i = 0; i < n; i++) begin
            root = gf_pow_alpha(fcr + i, poly);
            for (int j = i + 1; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root, poly);
            g[0] = gf_mul(g[0], root, poly);
        end
        res = '0;
        for (int j = 0; j < N_PARITY_MAX; j++) begin
            if (j < n) res[j] = g[j];
        end
        return res;
    endfunction

    function automatic gf_cols_t gf_const_cols(input logic [7:0] coef,
                                               input logic [8:0] poly);
        gf_cols_t cols;
        for (int j = 0; j < 8; j++) cols[j] = gf_mul(coef, 8'(1 << j), poly);
        return cols;
    endfunction

endpackage

// File: rtl/rs_enc_stage.sv
// -----------------------------------------------------------------------------
// rs_enc_stage
// One LFSR parity stage: r <= prev ^ (COEF * fb) when enabled. The constant
// multiplier is a fixed XOR network derived from COEF and PRIM_POLY.
// Ports:
//   clk     clock
//   rst     asynchronous active-low reset
//   en_i    shift enable (input transfer or parity emission)
//   fb_i    feedback symbol (zero while emitting parity)
//   prev_i  previous stage register (zero for stage 0)
//   r_o     this stage's parity register
// -----------------------------------------------------------------------------
module rs_enc_stage
    import rs_enc_pkg::*;
#(
    parameter logic [7:0] COEF      = 8'h01,
    parameter logic [8:0] PRIM_POLY = PRIM_POLY_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [7:0] fb_i,
    input  logic [7:0] prev_i,
    output logic [7:0] r_o
);

    localparam gf_cols_t COLS = gf_const_cols(COEF, PRIM_POLY);

    logic [7:0] prod;
    logic [7:0] r_d;
    logic [7:0] r_q;

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        prod = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (fb_i[j]) prod = prod ^ COLS[j];
        end
        r_d = prev_i ^ prod;
    end

    // NOTE: sequential state uses non-blocking assignments so all stages
    // sample their neighbours' old values on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= 8'h00;
        end else if (en_i) begin
            r_q <= r_d;
        end
    end

    assign r_o = r_q;

endmodule

// File: rtl/rs_enc_lfsr.sv
// -----------------------------------------------------------------------------
// rs_enc_lfsr
// Systematic Reed-Solomon encoder over GF(2^8) with valid/ready streaming.
// Message symbols pass straight through, then N_PARITY parity symbols follow
// (highest-degree parity first). Generator coefficients are computed at
// elaboration from PRIM_POLY and FCR.
// Optional feature macro: RS_ENC_LEN_CHECK_EN -- force the K_MAX-th message
// symbol to end the message and raise a sticky len_err.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   in_data/in_valid/in_last   message symbol stream from the framer
//   in_ready                   encoder accepts in_data this cycle
//   out_data/out_valid/out_last codeword stream; out_last on final parity
//   out_ready                  downstream accepts out_data
//   len_err                    sticky length error (0 without the macro)
// -----------------------------------------------------------------------------
module rs_enc_lfsr
    import rs_enc_pkg::*;
#(
    parameter int         N_PARITY  = 16,
    parameter logic [8:0] PRIM_POLY = PRIM_POLY_DEF,
    parameter int         FCR       = FCR_DEF,
    parameter int         K_MAX     = 239
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       len_err
);

    if (N_PARITY < 2 || N_PARITY > N_PARITY_MAX || K_MAX < 1 || K_MAX > 255) begin : g_param_check
        $error("rs_enc_lfsr: parameter out of range");
    end

    localparam gen_coef_t GEN = gen_poly(N_PARITY, PRIM_POLY, FCR);
    localparam int        CW  = $clog2(N_PARITY);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;

    logic [7:0]    r [N_PARITY];
    logic [7:0]    fb;
    logic          free, xfer, par_step, par_last, shift_en, msg_last;

    // The output slot can take a new symbol when empty or being drained.
    assign free     = !out_valid_q || out_ready;
    assign in_ready = free && (state_q != ST_PARITY);
    assign xfer     = in_valid && in_ready;
    assign par_step = free && (state_q == ST_PARITY);
    assign par_last = par_step && (cnt_q == CW'(N_PARITY - 1));
    assign shift_en = xfer || par_step;
    // Zero feedback during parity turns the LFSR into a plain shift register.
    assign fb       = xfer ? (in_data ^ r[N_PARITY-1]) : 8'h00;

`ifdef RS_ENC_LEN_CHECK_EN
    logic [7:0] msg_cnt_q, msg_cnt_d;
    logic       len_err_q, len_err_d;
    logic       at_limit;

    assign at_limit = (msg_cnt_q == 8'(K_MAX - 1));
    assign msg_last = in_last || at_limit;

    always_comb begin
        msg_cnt_d = msg_cnt_q;
        len_err_d = len_err_q;
        if (xfer) begin
            msg_cnt_d = msg_last ? 8'h00 : msg_cnt_q + 8'h01;
            if (at_limit && !in_last) len_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_cnt_q <= 8'h00;
            len_err_q <= 1'b0;
        end else begin
            msg_cnt_q <= msg_cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign len_err = len_err_q;
`else
    assign msg_last = in_last;
    assign len_err  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (xfer) begin
            out_data_d  = in_data;
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
            state_d     = msg_last ? ST_PARITY : ST_MSG;
        end else if (par_step) begin
            out_data_d  = r[N_PARITY-1];
            out_last_d  = par_last;
            out_valid_d = 1'b1;
            cnt_d       = par_last ? '0 : cnt_q + 1'b1;
            if (par_last) state_d = ST_IDLE;
        end else if (free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    for (genvar i = 0; i < N_PARITY; i++) begin : g_stage
        logic [7:0] prev;
        if (i == 0) begin : g_first
            assign prev = 8'h00;
        end else begin : g_chain
            assign prev = r[i-1];
        end
        rs_enc_stage #(
            .COEF      (GEN[i]),
            .PRIM_POLY (PRIM_POLY)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en_i   (shift_en),
            .fb_i   (fb),
            .prev_i (prev),
            .r_o    (r[i])
        );
    end

endmodule

// File: tb/tb_rs_enc_lfsr.sv
// -----------------------------------------------------------------------------
// tb_rs_enc_lfsr
// Directed bench for rs_enc_lfsr. u_dut uses N_PARITY=16; u_dut2 uses
// N_PARITY=2, K_MAX=4 so its codewords can be worked by hand.
// Codeword correctness for N_PARITY=16 is judged by evaluating syndromes
// at alpha^0..alpha^15 over the captured output stream.
// -----------------------------------------------------------------------------
module tb_rs_enc_lfsr;

    localparam int NP = 16;

    logic       clk;
    logic       rst;

    logic [7:0] in_data, out_data;
    logic       in_valid, in_last, in_ready, out_valid, out_last, out_ready, len_err;

    logic [7:0] in_data2, out_data2;
    logic       in_valid2, in_last2, in_ready2, out_valid2, out_last2, out_ready2, len_err2;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] cap_d [$];
    logic       cap_l [$];

    rs_enc_lfsr #(.N_PARITY(NP)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .len_err   (len_err)
    );

    rs_enc_lfsr #(.N_PARITY(2), .K_MAX(4)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data2),
        .in_valid  (in_valid2),
        .in_last   (in_last2),
        .in_ready  (in_ready2),
        .out_data  (out_data2),
        .out_valid (out_valid2),
        .out_last  (out_last2),
        .out_ready (out_ready2),
        .len_err   (len_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tb_gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return p;
    endfunction

    // Number of nonzero syndromes S_i = c(alpha^i), i=0..n-1, for the
    // codeword held in q[start +: cnt], first symbol = highest degree.
    function automatic int syn_fail(input logic [7:0] q [$], input int start,
                                    input int cnt, input int n);
        int         bad;
        logic [7:0] root;
        logic [7:0] s;
        bad  = 0;
        root = 8'h01;
        for (int i = 0; i < n; i++) begin
            s = 8'h00;
            for (int j = 0; j < cnt; j++) s = tb_gf_mul(s, root) ^ q[start + j];
            if (s != 8'h00) bad++;
            root = tb_gf_mul(root, 8'h02);
        end
        return bad;
    endfunction

    // Drive one codeword through u_dut and check it. kind: 0 zeros,
    // 1 ramp 0,1,2..., 2 random. ready_pct: out_ready probability in percent.
    task automatic run_cw(input string tag, input int len, input int kind, input int ready_pct);
        logic [7:0] msg [$];
        int         idx, cycles, mism, early_last;
        logic       done, stall, held_l;
        logic [7:0] held_d;
        msg.delete();
        for (int i = 0; i < len; i++) begin
            case (kind)
                0:       msg.push_back(8'h00);
                1:       msg.push_back(8'(i));
                default: msg.push_back(8'($urandom_range(0, 255)));
            endcase
        end
        cap_d.delete();
        cap_l.delete();
        idx = 0; cycles = 0; done = 1'b0; stall = 1'b0; held_d = 8'h00; held_l = 1'b0;
        while (!done && cycles < 4000) begin
            @(negedge clk);
            if (stall) begin
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_data"}, 32'(out_data), 32'(held_d));
                check({tag, "_hold_last"}, 32'(out_last), 32'(held_l));
            end
            in_valid  = (idx < len);
            in_data   = (idx < len) ? msg[idx] : 8'h00;
            in_last   = (idx == len - 1);
            out_ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (out_valid && out_ready) begin
                cap_d.push_back(out_data);
                cap_l.push_back(out_last);
                if (out_last) done = 1'b1;
            end
            stall  = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (idx == len && !done) check({tag, "_in_ready_parity"}, 32'(in_ready), 32'd0);
            if (in_valid && in_ready) idx++;
            cycles++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_count"}, 32'(cap_d.size()), 32'(len + NP));
        mism = 0;
        early_last = 0;
        for (int i = 0; i < len && i < cap_d.size(); i++) begin
            if (cap_d[i] !== msg[i]) mism++;
        end
        for (int i = 0; i + 1 < cap_l.size(); i++) begin
            if (cap_l[i] !== 1'b0) early_last++;
        end
        check({tag, "_msg_passthru_mismatches"}, 32'(mism), 32'd0);
        check({tag, "_early_last"}, 32'(early_last), 32'd0);
        if (cap_d.size() == len + NP)
            check({tag, "_bad_syndromes"}, 32'(syn_fail(cap_d, 0, len + NP, NP)), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        in_data   = 8'h00; in_valid  = 1'b0; in_last  = 1'b0; out_ready  = 1'b0;
        in_data2  = 8'h00; in_valid2 = 1'b0; in_last2 = 1'b0; out_ready2 = 1'b1;

        // Reset state, observed after a clock edge with reset still held.
        #8;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        check("rst_out_valid2", 32'(out_valid2), 32'd0);
        #4 rst = 1'b1;

        // N_PARITY=2: message 0x01 -> 01, 03, 02 (g = x^2 + 03x + 02).
        @(negedge clk);
        in_valid2 = 1'b1; in_data2 = 8'h01; in_last2 = 1'b1;
        #1 check("np2_idle_in_ready", 32'(in_ready2), 32'd1);
        @(negedge clk);
        in_valid2 = 1'b0; in_last2 = 1'b0; in_data2 = 8'h00;
        #1;
        check("np2_sym0_valid", 32'(out_valid2), 32'd1);
        check("np2_sym0_data", 32'(out_data2), 32'h01);
        check("np2_sym0_last", 32'(out_last2), 32'd0);
        check("np2_parity_in_ready", 32'(in_ready2), 32'd0);
        @(negedge clk); #1;
        check("np2_par0_data", 32'(out_data2), 32'h03);
        check("np2_par0_last", 32'(out_last2), 32'd0);
        check("np2_par0_in_ready", 32'(in_ready2), 32'd0);
        @(negedge clk); #1;
        check("np2_par1_data", 32'(out_data2), 32'h02);
        check("np2_par1_last", 32'(out_last2), 32'd1);
        check("np2_after_last_in_ready", 32'(in_ready2), 32'd1);
        @(negedge clk); #1;
        check("np2_drained_valid", 32'(out_valid2), 32'd0);

        // N_PARITY=16: all-zero message, then ramp 0x00..0xEE.
        run_cw("zero239", 239, 0, 100);
        if (cap_d.size() == 255) check("zero239_parity_sym", 32'(cap_d[254]), 32'h00);
        run_cw("ramp239", 239, 1, 100);

        // Three back-to-back codewords under 50% backpressure.
        run_cw("bp_a", 5, 2, 50);
        run_cw("bp_b", 30, 2, 50);
        run_cw("bp_c", 1, 2, 50);

        // Reset in the middle of the parity phase.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = 8'(8'hA0 + i);
            in_last   = (i == 2);
            #1 check("rstmid_in_ready", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_out_last", 32'(out_last), 32'd0);
        check("rstmid_in_ready_idle", 32'(in_ready), 32'd1);
        #3 rst = 1'b1;
        run_cw("after_rst", 10, 1, 100);

`ifdef RS_ENC_LEN_CHECK_EN
        // K_MAX=4: six symbols, none marked last until the sixth.
        begin
            logic [7:0] syms [6];
            int         idx, cyc, lasts;
            syms[0] = 8'h11; syms[1] = 8'h22; syms[2] = 8'h33;
            syms[3] = 8'h44; syms[4] = 8'h55; syms[5] = 8'h66;
            cap_d.delete();
            cap_l.delete();
            idx = 0; cyc = 0; lasts = 0;
            out_ready2 = 1'b1;
            while (lasts < 2 && cyc < 100) begin
                @(negedge clk);
                in_valid2 = (idx < 6);
                in_data2  = (idx < 6) ? syms[idx] : 8'h00;
                in_last2  = (idx == 5);
                #1;
                if (out_valid2) begin
                    cap_d.push_back(out_data2);
                    cap_l.push_back(out_last2);
                    if (out_last2) lasts++;
                end
                if (in_valid2 && in_ready2) idx++;
                cyc++;
            end
            in_valid2 = 1'b0; in_last2 = 1'b0;
            check("len_count", 32'(cap_d.size()), 32'd10);
            if (cap_d.size() == 10) begin
                check("len_sym3", 32'(cap_d[3]), 32'h44);
                check("len_last_first_cw", 32'(cap_l[5]), 32'd1);
                check("len_sym5_starts_next", 32'(cap_d[6]), 32'h55);
                check("len_sym6", 32'(cap_d[7]), 32'h66);
                check("len_last_second_cw", 32'(cap_l[9]), 32'd1);
                check("len_syn_first", 32'(syn_fail(cap_d, 0, 6, 2)), 32'd0);
                check("len_syn_second", 32'(syn_fail(cap_d, 6, 4, 2)), 32'd0);
            end
            check("len_err_set", 32'(len_err2), 32'd1);
            repeat (3) @(negedge clk);
            #1 check("len_err_sticky", 32'(len_err2), 32'd1);
        end
`else
        check("len_err_tied_np16", 32'(len_err), 32'd0);
        check("len_err_tied_np2", 32'(len_err2), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
